hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core.
- Consumes per-instruction Tuse/Tnew codes from the D-stage decoder and tracks in-flight destination registers in the E, M and W stages.
- Drives stall/bubble and all forwarding-mux selects.
- Sequences the multi-cycle mult/div unit through a busy counter, stalling HI/LO accessors until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu
- DIV_CYCLES, 10, busy cycles loaded for div/divu

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- ext_stall  in  1  memory wait: freeze whole pipeline
- d_rs  in  5  D-stage rs index
- d_rt  in  5  D-stage rt index
- d_tuse_rs  in  2  cycles until D needs rs (3 = unused)
- d_tuse_rt  in  2  cycles until D needs rt (3 = unused)
- d_a3  in  5  D-stage destination index (0 = none)
- d_tnew  in  2  cycles from E entry until result ready (3 = no write)
- d_md_start  in  1  D instr is mult/div
- d_md_div  in  1  1 = div class, 0 = mult class
- d_md_use  in  1  D instr is mfhi/mflo/mthi/mtlo
- stall  out  1  hold PC and F/D register, insert bubble into E
- fwd_rs_d  out  2  D-stage rs source select (branch/jr compare)
- fwd_rt_d  out  2  D-stage rt source select
- fwd_rs_e  out  2  E-stage ALU A source select
- fwd_rt_e  out  2  E-stage ALU B source select
- fwd_rt_m  out  2  M-stage store-data source select
- md_busy  out  1  mult/div counter non-zero

Behaviour:
- Select codes: 0 = register/pipe value, 1 = E result (PC+8), 2 = M result, 3 = W result.
- State registers:
  - E entry {a3, tnew, rs, rt}.
  - M entry {a3, tnew, rt}.
  - W entry {a3, tnew}.
  - busy counter, 4 bits.
- Entry capture: d_tnew == 3 is stored as a3 = 0.
- Reset (reset low, async): all entries are a3 = 0, tnew = 0, rs = rt = 0; busy = 0. Combinationally this gives stall = 0, all fwd = 0, md_busy = 0.
- Advance each clk edge when ext_stall = 0:
  - E loads the D entry, or a bubble (all zero) when stall = 1.
  - M loads E with tnew saturating-decremented (0 stays 0).
  - W loads M with tnew saturating-decremented.
- ext_stall = 1: E, M and W hold. The busy counter still decrements.
- Stall logic (combinational from registered state and D inputs):
  - stall_rs = rs != 0 and (E.a3 == rs and E.tnew > tuse_rs, or M.a3 == rs and M.tnew > tuse_rs). stall_rt is symmetric.
  - stall_md = d_md_use and (busy != 0 or the E entry is an md_start).
  - stall = stall_rs or stall_rt or stall_md.
- Forwarding: for each consumer index r (r != 0), check producers newest first and take the first that matches a3 == r with tnew == 0.
  - D consumers: E(1), M(2), W(3).
  - E consumers: M(2), W(3).
  - M consumer (rt): W(3).
  - No match: 0.
  - A matching producer with tnew != 0 blocks lookup to older stages; stall covers that case.
- Register $0 never stalls and never forwards.
- Busy counter:
  - On an advance that moves an md_start into E, load MULT_CYCLES or DIV_CYCLES per the class flag carried in E.
  - Otherwise decrement while non-zero.
  - A new md_start while busy != 0 also stalls (treated as d_md_use).
- Stall and ext_stall both asserted: ext_stall dominates, so no bubble is inserted and nothing moves.
- Reset mid-operation clears the busy counter immediately; no partial state survives.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_REG/FWD_E/FWD_M/FWD_W constants.
  - TUSE_NONE = 3 and TNEW_NONE = 3.
  - Stage-entry struct {a3, tnew, rs, rt, md}.
  - MULT/DIV default latencies.
- One sub-module, hazard_md_busy: load/decrement counter with async active-low reset and a busy output.

Test Plan:
1. lw $1 then addu $2,$1,$3 → stall = 1 for exactly one cycle, E bubble. Next cycle fwd_rs_e = 3 (W).
2. addu $1 then beq $1,$0 → one stall cycle, then fwd_rs_d = 2 (M).
3. lw $1 then beq $1 → two stall cycles, then fwd_rs_d = 3.
4. jal then jr $31 → no stall, fwd_rs_d = 1 (E, PC+8).
5. lw $5 then sw $5,0($6) → no stall; at M, fwd_rt_m = 3.
6. mult then mflo → md_busy rises, stall holds for 5 cycles after mult enters E (10 for div).
7. Assert reset at busy = 3 → md_busy = 0 and stall = 0 immediately.
8. ext_stall during a lw-use stall → no bubble, state frozen; stall resumes when ext_stall drops.
9. Any hazard pattern on $0 → stall = 0, all fwd = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types, select codes and helpers for the hazard scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int BUSY_W          = 4;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       md_start;
        logic       md_div;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    function automatic stage_t age(input stage_t s);
        age = s;
        if (s.tnew != 2'd0) begin
            age.tnew = s.tnew - 2'd1;
        end
    endfunction

    function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                        input logic [4:0] m_a3, input logic [1:0] m_tnew);
        return (r != 5'd0) &&
               (((e_a3 == r) && (e_tnew > tuse)) || ((m_a3 == r) && (m_tnew > tuse)));
    endfunction

    // Newest producer wins; a newer match whose result is not ready blocks older stages.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                           input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                           input logic [4:0] w_a3, input logic [1:0] w_tnew);
        fwd_sel = FWD_REG;
        if (r != 5'd0) begin
            if (e_a3 == r) begin
                fwd_sel = (e_tnew == 2'd0) ? FWD_E : FWD_REG;
            end else if (m_a3 == r) begin
                fwd_sel = (m_tnew == 2'd0) ? FWD_M : FWD_REG;
            end else if (w_a3 == r) begin
                fwd_sel = (w_tnew == 2'd0) ? FWD_W : FWD_REG;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_if.sv
// ============================================================================
// Module   : hazard_if
// Brief    : Decoder-side inputs and stall/forward outputs of the hazard unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_if;

    logic       ext_stall;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_a3;
    logic [1:0] d_tnew;
    logic       d_md_start;
    logic       d_md_div;
    logic       d_md_use;

    logic       stall;
    logic [1:0] fwd_rs_d;
    logic [1:0] fwd_rt_d;
    logic [1:0] fwd_rs_e;
    logic [1:0] fwd_rt_e;
    logic [1:0] fwd_rt_m;
    logic       md_busy;

    modport master (
        output ext_stall, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  ext_stall, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

endinterface

`default_nettype wire

// File: rtl/hazard_md_busy.sv
// ============================================================================
// Module   : hazard_md_busy
// Brief    : Load/decrement busy counter for the multi-cycle mult/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_md_busy
    import hazard_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic [BUSY_W-1:0] i_load_val,
    output logic                   o_busy
);

    logic [BUSY_W-1:0] r_cnt;

    // Decrement continues regardless of pipeline freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/bubble and forwarding scheduler for the 5-stage MIPS core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  wire logic clk,
    input  wire logic reset,
    hazard_if.slave   hif
);

    stage_t            r_e;
    stage_t            r_m;
    stage_t            r_w;
    stage_t            w_d_entry;
    logic              w_adv;
    logic              w_stall_rs;
    logic              w_stall_rt;
    logic              w_stall_md;
    logic              w_stall;
    logic              w_md_busy;
    logic              w_md_load;
    logic [BUSY_W-1:0] w_md_load_val;
    logic              w_unused;

    always_comb begin
        w_d_entry          = STAGE_EMPTY;
        w_d_entry.a3       = (hif.d_tnew == TNEW_NONE) ? 5'd0 : hif.d_a3;
        w_d_entry.tnew     = hif.d_tnew;
        w_d_entry.rs       = hif.d_rs;
        w_d_entry.rt       = hif.d_rt;
        w_d_entry.md_start = hif.d_md_start;
        w_d_entry.md_div   = hif.d_md_div;
    end

    assign w_stall_rs = src_hazard(hif.d_rs, hif.d_tuse_rs, r_e.a3, r_e.tnew, r_m.a3, r_m.tnew);
    assign w_stall_rt = src_hazard(hif.d_rt, hif.d_tuse_rt, r_e.a3, r_e.tnew, r_m.a3, r_m.tnew);
    // A second mult/div issued behind a busy unit waits like an HI/LO accessor.
    assign w_stall_md = (hif.d_md_use || hif.d_md_start) && (w_md_busy || r_e.md_start);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    assign w_adv      = !hif.ext_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e <= STAGE_EMPTY;
            r_m <= STAGE_EMPTY;
            r_w <= STAGE_EMPTY;
        end else if (w_adv) begin
            r_e <= w_stall ? STAGE_EMPTY : w_d_entry;
            r_m <= age(r_e);
            r_w <= age(r_m);
        end
    end

    assign w_md_load     = w_adv && !w_stall && hif.d_md_start;
    assign w_md_load_val = hif.d_md_div ? BUSY_W'(DIV_CYCLES) : BUSY_W'(MULT_CYCLES);

    hazard_md_busy u_md_busy (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_md_load),
        .i_load_val (w_md_load_val),
        .o_busy     (w_md_busy)
    );

    assign hif.stall    = w_stall;
    assign hif.md_busy  = w_md_busy;
    assign hif.fwd_rs_d = fwd_sel(hif.d_rs, r_e.a3, r_e.tnew, r_m.a3, r_m.tnew, r_w.a3, r_w.tnew);
    assign hif.fwd_rt_d = fwd_sel(hif.d_rt, r_e.a3, r_e.tnew, r_m.a3, r_m.tnew, r_w.a3, r_w.tnew);
    assign hif.fwd_rs_e = fwd_sel(r_e.rs, 5'd0, 2'd0, r_m.a3, r_m.tnew, r_w.a3, r_w.tnew);
    assign hif.fwd_rt_e = fwd_sel(r_e.rt, 5'd0, 2'd0, r_m.a3, r_m.tnew, r_w.a3, r_w.tnew);
    assign hif.fwd_rt_m = fwd_sel(r_m.rt, 5'd0, 2'd0, 5'd0, 2'd0, r_w.a3, r_w.tnew);

    // Fields carried for uniformity but not consulted in later stages.
    assign w_unused = ^{r_e.md_div, r_m.rs, r_m.md_start, r_m.md_div,
                        r_w.rs, r_w.rt, r_w.md_start, r_w.md_div};

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl using hand-derived pipeline traces.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [11:0] exp_q[$];

    hazard_if hif();

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [11:0] ex(input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                                       input logic [1:0] rse, input logic [1:0] rte,
                                       input logic [1:0] rtm, input logic bz);
        return {st, rsd, rtd, rse, rte, rtm, bz};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mdu);
        hif.d_rs       = rs;
        hif.d_rt       = rt;
        hif.d_tuse_rs  = tu_rs;
        hif.d_tuse_rt  = tu_rt;
        hif.d_a3       = a3;
        hif.d_tnew     = tnew;
        hif.d_md_start = mds;
        hif.d_md_div   = mdd;
        hif.d_md_use   = mdu;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got stall %0d expected an entry", tag, hif.stall);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".stall"},    32'(hif.stall),    32'(e[11]));
        chk({tag, ".fwd_rs_d"}, 32'(hif.fwd_rs_d), 32'(e[10:9]));
        chk({tag, ".fwd_rt_d"}, 32'(hif.fwd_rt_d), 32'(e[8:7]));
        chk({tag, ".fwd_rs_e"}, 32'(hif.fwd_rs_e), 32'(e[6:5]));
        chk({tag, ".fwd_rt_e"}, 32'(hif.fwd_rt_e), 32'(e[4:3]));
        chk({tag, ".fwd_rt_m"}, 32'(hif.fwd_rt_m), 32'(e[2:1]));
        chk({tag, ".md_busy"},  32'(hif.md_busy),  32'(e[0]));
    endtask

    // Called at posedge+1: settle, compare, then move to the next posedge+1.
    task automatic cyc(input string tag, input logic [11:0] e);
        exp_q.push_back(e);
        #3;
        check_out(tag);
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] Z = 12'd0;

    initial begin
        reset = 1'b0;
        hif.ext_stall = 1'b0;
        nop();
        #2;
        exp_q.push_back(Z);
        check_out("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // lw $1 ; addu $2,$1,$3
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0); cyc("t1.lw", Z);
        drive(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0); cyc("t1.stall", ex(1,0,0,0,0,0,0));
        cyc("t1.go", Z);
        nop(); cyc("t1.fwdW", ex(0,0,0,3,0,0,0));
        cyc("t1.d1", Z); cyc("t1.d2", Z);

        // addu $1 ; beq $1,$0
        drive(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0); cyc("t2.addu", Z);
        drive(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t2.stall", ex(1,0,0,0,0,0,0));
        cyc("t2.fwdM", ex(0,2,0,0,0,0,0));
        nop(); cyc("t2.e", ex(0,0,0,3,0,0,0));
        cyc("t2.d1", Z); cyc("t2.d2", Z);

        // lw $1 ; beq $1,$0
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0); cyc("t3.lw", Z);
        drive(5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t3.stall1", ex(1,0,0,0,0,0,0));
        cyc("t3.stall2", ex(1,0,0,0,0,0,0));
        cyc("t3.fwdW", ex(0,3,0,0,0,0,0));
        nop(); cyc("t3.d1", Z); cyc("t3.d2", Z); cyc("t3.d3", Z);

        // jal ; jr $31
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0); cyc("t4.jal", Z);
        drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t4.fwdE", ex(0,1,0,0,0,0,0));
        nop(); cyc("t4.e", ex(0,0,0,2,0,0,0));
        cyc("t4.d1", Z); cyc("t4.d2", Z);

        // lw $5 ; sw $5,0($6)
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0); cyc("t5.lw", Z);
        drive(5'd6, 5'd5, 2'd1, 2'd2, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t5.sw", Z);
        nop(); cyc("t5.e", Z);
        cyc("t5.fwdWm", ex(0,0,0,0,0,3,0));
        cyc("t5.d1", Z);

        // mult ; mflo, then div ; mflo
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 5 : 10;
            drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd3, 1'b1, k[0], 1'b0); cyc("t6.start", Z);
            drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < n; i++) cyc("t6.busy", ex(1,0,0,0,0,0,1));
            cyc("t6.free", Z);
            nop(); cyc("t6.d1", Z); cyc("t6.d2", Z);
        end

        // mult ; reset asserted while count is 3 and a second mult waits
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd3, 1'b1, 1'b0, 1'b0); cyc("t7.mult", Z);
        nop(); cyc("t7.b5", ex(0,0,0,0,0,0,1));
        cyc("t7.b4", ex(0,0,0,0,0,0,1));
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd3, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(ex(1,0,0,0,0,0,1));
        #3; check_out("t7.b3");
        reset = 1'b0;
        exp_q.push_back(Z);
        #1; check_out("t7.rst");
        @(posedge clk); #1;
        reset = 1'b1;
        nop(); cyc("t7.after", Z);

        // lw $1 ; addu $2,$1,$3 with ext_stall over the stall window
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0); cyc("t8.lw", Z);
        drive(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        hif.ext_stall = 1'b1;
        cyc("t8.frz1", ex(1,0,0,0,0,0,0));
        cyc("t8.frz2", ex(1,0,0,0,0,0,0));
        hif.ext_stall = 1'b0;
        cyc("t8.stall", ex(1,0,0,0,0,0,0));
        cyc("t8.go", Z);
        nop(); cyc("t8.fwdW", ex(0,0,0,3,0,0,0));
        cyc("t8.d1", Z); cyc("t8.d2", Z);

        // $0 producers and a no-write destination never stall or forward
        drive(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0); cyc("t9.lw0", Z);
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t9.beq0", Z);
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t9.nowr", Z);
        drive(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd3, 1'b0, 1'b0, 1'b0); cyc("t9.jr5", Z);
        nop(); cyc("t9.d1", Z); cyc("t9.d2", Z);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
